// File: rtl/nn_fetch_pkg.sv
// Shared defaults, FSM encoding and requester slot numbers for the fetch arbiter.
package nn_fetch_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int AW_DEF    = 16;
  localparam int DW_DEF    = 16;
  localparam int LW_DEF    = 8;

  localparam int REQ_PIXEL    = 0;
  localparam int REQ_L0_PARAM = 1;
  localparam int REQ_L1_VALUE = 2;
  localparam int REQ_L1_PARAM = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_rr_picker.sv
// Rotating-priority picker: first set req bit at or after ptr wins.
// Fixed priority is the same search with ptr held at 0.
module fetch_rr_picker #(
  parameter int N  = 4,
  parameter int PW = 2
)(
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  oh,
  output logic [PW-1:0] idx,
  output logic          any
);
  always_comb begin
    int j;
    oh  = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any   = 1'b1;
        oh[j] = 1'b1;
        idx   = PW'(j);
      end
    end
  end
endmodule

// File: rtl/fetch_arbiter.sv
// Burst fetch arbiter: grants one requester, streams its reads to memory, returns data.
// Define FETCH_ARB_RR_EN for round-robin; default build is fixed lowest-index priority.
module fetch_arbiter
  import nn_fetch_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int LW     = LW_DEF,
  parameter int RD_LAT = 2
)(
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*LW-1:0] req_len,
  output logic [N_REQ-1:0]    gnt,
  output logic               mem_en,
  output logic [AW-1:0]      mem_addr,
  input  logic [DW-1:0]      mem_rdata,
  output logic [DW-1:0]      rd_data,
  output logic [N_REQ-1:0]    rd_valid,
  output logic [N_REQ-1:0]    done,
  output logic               busy
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  fetch_state_e     state_q;
  logic [N_REQ-1:0] gnt_q, pick_oh;
  logic [PW-1:0]    ptr, pick_idx;
  logic             pick_any;
  logic [AW-1:0]    addr_q;
  logic [LW-1:0]    rem_q, pick_len;
  logic             mem_en_q;
  logic [DW-1:0]    rd_data_q;
  logic [RD_LAT:1]  vld_pipe_q, last_pipe_q;
  logic [RD_LAT:0]  vld_all, last_all;

  fetch_rr_picker #(.N(N_REQ), .PW(PW)) u_pick (
    .req (req),
    .ptr (ptr),
    .oh  (pick_oh),
    .idx (pick_idx),
    .any (pick_any)
  );

`ifdef FETCH_ARB_RR_EN
  logic [PW-1:0] ptr_q;
  always_ff @(posedge clk) begin
    if (reset)
      ptr_q <= '0;
    else if (state_q == ST_IDLE && pick_any)
      ptr_q <= (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + PW'(1);
  end
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  assign pick_len = req_len[pick_idx*LW +: LW];

  // Burst FSM; rem_q counts reads still to issue, including the one on the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      mem_en_q <= 1'b0;
      addr_q   <= '0;
      rem_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (pick_any) begin
          gnt_q    <= pick_oh;
          addr_q   <= req_addr[pick_idx*AW +: AW];
          rem_q    <= (pick_len == '0) ? LW'(1) : pick_len;
          mem_en_q <= 1'b1;
          state_q  <= ST_ISSUE;
        end
        ST_ISSUE: if (rem_q == LW'(1)) begin
          mem_en_q <= 1'b0;
          state_q  <= ST_DRAIN;
        end else begin
          rem_q  <= rem_q - LW'(1);
          addr_q <= addr_q + AW'(1);
        end
        ST_DRAIN: if (last_pipe_q[RD_LAT]) begin
          gnt_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Stage k of the pipe holds reads issued k cycles ago; stage 0 is the live issue.
  assign vld_all  = {vld_pipe_q, mem_en_q};
  assign last_all = {last_pipe_q, mem_en_q && (rem_q == LW'(1))};

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      rd_data_q   <= '0;
    end else begin
      for (int k = RD_LAT; k >= 1; k--) begin
        vld_pipe_q[k]  <= vld_all[k-1];
        last_pipe_q[k] <= last_all[k-1];
      end
      if (vld_all[RD_LAT-1]) rd_data_q <= mem_rdata;
    end
  end

  assign gnt      = gnt_q;
  assign mem_en   = mem_en_q;
  assign mem_addr = addr_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = vld_pipe_q[RD_LAT]  ? gnt_q : '0;
  assign done     = last_pipe_q[RD_LAT] ? gnt_q : '0;
  assign busy     = (state_q != ST_IDLE);

endmodule
